// File: rtl/red_pitaya_fads_sort_scheduler_if.sv
// System-bus interface for the FADS sort scheduler.
// The master drives address, data and strobes; the slave answers with data and ack.
interface red_pitaya_fads_sort_scheduler_if;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic [3:0]  sys_sel;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;

    modport master (
        output sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
        input  sys_rdata, sys_err, sys_ack
    );

    modport slave (
        input  sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
        output sys_rdata, sys_err, sys_ack
    );
endinterface

// File: rtl/red_pitaya_fads_sort_scheduler.sv
// FADS sort scheduler: timestamps droplet sort requests into a FIFO of deadlines and
// fires one electrode pulse per entry once its deadline is reached.
// Optional statistics counters (accepted/fired/overflow/late) are built only when the
// macro FADS_SCHED_STATS_EN is defined; otherwise 0x10-0x1C read as 0.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | queue empty, nothing scheduled; delay shadow may update
// ST_WAIT  | head entry pending, waiting for its deadline
// ST_PULSE | trigger high, pulse timer counting down
// ST_GAP   | one forced low cycle between consecutive pulses
module red_pitaya_fads_sort_scheduler #(
    parameter int QLOG = 3,
    parameter int TW   = 32
) (
    input  logic adc_clk_i,
    input  logic adc_rstn_i,
    input  logic sort_req_i,
    output logic sort_trig_o,
    output logic busy_o,
    red_pitaya_fads_sort_scheduler_if.slave bus
);

    localparam int DEPTH = 1 << QLOG;
    localparam logic [QLOG:0] FULL_CNT = (QLOG + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_PULSE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   now;
    logic [TW-1:0]   act_delay;
    logic [TW-1:0]   sort_delay;
    logic [TW-1:0]   sort_duration;
    logic [TW-1:0]   pulse_cnt;
    logic            enable;
    logic            trig;
    logic [TW-1:0]   queue [DEPTH];
    logic [QLOG-1:0] wr_ptr, rd_ptr;
    logic [QLOG:0]   count;
    logic            full, empty;
    logic [TW-1:0]   head, since_head;
    logic            head_due;
    logic            pop, push, drop, late, req_ok;
    logic [19:0]     addr;
    logic            wr_ctrl, flush, clr_cnt;
    logic [31:0]     rd_val, status;
    logic [31:0]     rdata;
    logic            ack;
    logic            unused_bus;

    assign addr    = bus.sys_addr[19:0];
    assign wr_ctrl = bus.sys_wen && (addr == 20'h00000);
    assign flush   = wr_ctrl && bus.sys_wdata[1];
    assign clr_cnt = wr_ctrl && bus.sys_wdata[2];

    // Byte selects and upper address bits have no meaning for this block.
    assign unused_bus = ^{bus.sys_sel, bus.sys_addr[31:20]};

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Wrap-safe due test: the head is due once now has reached or passed it.
    assign head       = queue[rd_ptr];
    assign since_head = now - head;
    assign head_due   = !empty && !since_head[TW-1];

    // A request at a full queue still gets in if the head leaves in the same cycle.
    assign req_ok = sort_req_i && enable && !flush;
    assign push   = req_ok && (!full || pop);
    assign drop   = req_ok && full && !pop;
    assign late   = pop && (since_head != '0);

    assign busy_o      = !empty || (state != ST_IDLE);
    assign sort_trig_o = trig;

    // Free-running timebase.
    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i) now <= '0;
        else             now <= now + TW'(1);
    end

    // FSM state register.
    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i) state <= ST_IDLE;
        else             state <= state_nxt;
    end

    // FSM next-state and pop decision; flush overrides everything.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            ST_IDLE:  if (!empty) state_nxt = ST_WAIT;
            ST_WAIT:  if (head_due) begin
                          state_nxt = ST_PULSE;
                          pop       = 1'b1;
                      end
            ST_PULSE: if (pulse_cnt == '0) state_nxt = ST_GAP;
            ST_GAP:   state_nxt = empty ? ST_IDLE : ST_WAIT;
            default:  state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            state_nxt = ST_IDLE;
            pop       = 1'b0;
        end
    end

    // Registered trigger and pulse-length down-counter (duration 0 behaves as 1).
    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i) begin
            trig      <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            trig <= (state_nxt == ST_PULSE);
            if (pop)
                pulse_cnt <= (sort_duration == '0) ? '0 : sort_duration - TW'(1);
            else if (state == ST_PULSE && pulse_cnt != '0)
                pulse_cnt <= pulse_cnt - TW'(1);
        end
    end

    // Deadline storage; the timestamp is the cycle the entry lands in the queue.
    always_ff @(posedge adc_clk_i) begin
        if (push) queue[wr_ptr] <= now + act_delay + TW'(1);
    end

    // Queue pointers and occupancy.
    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{QLOG{1'b0}}, push} - {{QLOG{1'b0}}, pop};
        end
    end

    // Configuration registers; the active delay only changes while nothing is queued,
    // so deadlines in the queue stay monotonic.
    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i) begin
            enable        <= 1'b1;
            sort_delay    <= TW'(31250);
            sort_duration <= TW'(125000);
            act_delay     <= TW'(31250);
        end else begin
            if (wr_ctrl) enable <= bus.sys_wdata[0];
            if (bus.sys_wen && addr == 20'h00004) sort_delay    <= TW'(bus.sys_wdata);
            if (bus.sys_wen && addr == 20'h00008) sort_duration <= TW'(bus.sys_wdata);
            if (empty && state == ST_IDLE) act_delay <= sort_delay;
        end
    end

`ifdef FADS_SCHED_STATS_EN
    logic [TW-1:0] cnt_accepted, cnt_fired, cnt_overflow, cnt_late;

    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v, input logic en);
        return (en && v != '1) ? v + TW'(1) : v;
    endfunction

    // Saturating event counters.
    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i || clr_cnt) begin
            cnt_accepted <= '0;
            cnt_fired    <= '0;
            cnt_overflow <= '0;
            cnt_late     <= '0;
        end else begin
            cnt_accepted <= sat_inc(cnt_accepted, push);
            cnt_fired    <= sat_inc(cnt_fired, pop);
            cnt_overflow <= sat_inc(cnt_overflow, drop);
            cnt_late     <= sat_inc(cnt_late, late);
        end
    end
`else
    logic unused_stats;
    assign unused_stats = ^{clr_cnt, drop, late};
`endif

    // Read decode.
    always_comb begin
        status              = '0;
        status[QLOG:0]      = count;
        status[16]          = trig;
        status[17]          = full;
        status[19:18]       = state;
        rd_val              = '0;
        case (addr)
            20'h00000: rd_val[0] = enable;
            20'h00004: rd_val    = 32'(sort_delay);
            20'h00008: rd_val    = 32'(sort_duration);
            20'h0000C: rd_val    = status;
`ifdef FADS_SCHED_STATS_EN
            20'h00010: rd_val    = 32'(cnt_accepted);
            20'h00014: rd_val    = 32'(cnt_fired);
            20'h00018: rd_val    = 32'(cnt_overflow);
            20'h0001C: rd_val    = 32'(cnt_late);
`endif
            default:   rd_val    = '0;
        endcase
    end

    // Bus response: one-cycle ack, registered read data.
    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i) begin
            ack   <= 1'b0;
            rdata <= '0;
        end else begin
            ack <= bus.sys_wen | bus.sys_ren;
            if (bus.sys_ren) rdata <= rd_val;
        end
    end

    assign bus.sys_ack   = ack;
    assign bus.sys_rdata = rdata;
    assign bus.sys_err   = 1'b0;

endmodule
